ex_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline stage: successor to the plain EX/MEM latch. Adds a valid/ready handshake, a 2-entry skid buffer (full throughput with a registered upstream ready), synchronous flush for branch squash, bubble gating of side-effect controls, and a saturating stall counter for debug. Sits between the EX stage (ALU, branch-address adder) and the MEM stage (data memory, branch resolution).

---
 rtl/ex_mem_stage.sv | 141 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage with valid/ready handshake and a two-entry skid buffer.
// The head ("main") entry drives the MEM_* outputs. The skid entry catches the
// one extra instruction that EX may push while MEM stalls, so that EX_ready can
// come straight from a flop and still allow full throughput.
// Side-effect control bits are masked while the head entry holds no valid
// instruction. A saturating counter records stalled cycles for debug.
module ex_mem_stage #(
    parameter int                   NB_PC            = 32,
    parameter int                   NB_DATA          = 32,
    parameter int                   NB_REG           = 5,
    parameter int                   NB_CTRL          = 9,
    parameter int                   NB_CNT           = 16,
    parameter logic [NB_CTRL-1:0]   SIDE_EFFECT_MASK = 9'b0_0001_1101
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_flush,

    input  logic                    EX_valid,
    output logic                    EX_ready,
    input  logic [NB_CTRL-1:0]      EX_ctrl,
    input  logic [NB_PC-1:0]        EX_branch_addr,
    input  logic                    EX_zero,
    input  logic [NB_DATA-1:0]      EX_alu_result,
    input  logic [NB_DATA-1:0]      EX_data_a,
    input  logic [NB_REG-1:0]       EX_selected_reg,
    input  logic [NB_PC-1:0]        EX_pc,

    output logic                    MEM_valid,
    input  logic                    MEM_ready,
    output logic [NB_CTRL-1:0]      MEM_ctrl,
    output logic [NB_PC-1:0]        MEM_branch_addr,
    output logic                    MEM_zero,
    output logic [NB_DATA-1:0]      MEM_alu_result,
    output logic [NB_DATA-1:0]      MEM_data_a,
    output logic [NB_REG-1:0]       MEM_selected_reg,
    output logic [NB_PC-1:0]        MEM_pc,

    output logic [NB_CNT-1:0]       o_stall_count
);

    // The whole EX bundle travels as one flat vector. The field order must
    // match the unpacking onto the MEM_* outputs below.
    localparam int NB_PAY = NB_CTRL + NB_PC + 1 + NB_DATA + NB_DATA + NB_REG + NB_PC;

    logic [NB_PAY-1:0]  inPay;
    logic [NB_PAY-1:0]  mainPay_q;
    logic [NB_PAY-1:0]  mainPay_d;
    logic [NB_PAY-1:0]  skidPay_q;
    logic [NB_PAY-1:0]  skidPay_d;
    logic               mainValid_q;
    logic               mainValid_d;
    logic               skidValid_q;
    logic               skidValid_d;
    logic [NB_CNT-1:0]  stallCount_q;
    logic [NB_CNT-1:0]  stallCount_d;

    logic               acceptIn;
    logic               releaseOut;
    logic [NB_CTRL-1:0] mainCtrl;

    assign inPay = {EX_ctrl, EX_branch_addr, EX_zero, EX_alu_result,
                    EX_data_a, EX_selected_reg, EX_pc};

    assign {mainCtrl, MEM_branch_addr, MEM_zero, MEM_alu_result,
            MEM_data_a, MEM_selected_reg, MEM_pc} = mainPay_q;

    // Ready depends only on skid occupancy. MEM_ready never reaches EX_ready
    // combinationally, so the ready chain through the pipeline stays short.
    assign EX_ready   = !skidValid_q;
    assign MEM_valid  = mainValid_q;
    assign acceptIn   = EX_valid && EX_ready;
    assign releaseOut = mainValid_q && MEM_ready;

    // Bubbles must not write registers or memory, or resolve branches. Other
    // control bits are harmless, so they keep showing the stale payload.
    assign MEM_ctrl = mainValid_q ? mainCtrl : (mainCtrl & ~SIDE_EFFECT_MASK);

    assign o_stall_count = stallCount_q;

    // Next-state for the two entries. The main entry always holds the oldest
    // instruction. The skid entry fills only while main is stalled.
    always_comb begin
        mainValid_d = mainValid_q;
        skidValid_d = skidValid_q;
        mainPay_d   = mainPay_q;
        skidPay_d   = skidPay_q;

        if (i_flush) begin
            // A squash drops everything, including a same-cycle accept.
            // Payload contents are left stale because they are gated by
            // the valid bits.
            mainValid_d = 1'b0;
            skidValid_d = 1'b0;
        end else if (!mainValid_q) begin
            if (acceptIn) begin
                mainPay_d   = inPay;
                mainValid_d = 1'b1;
            end
        end else if (releaseOut) begin
            if (skidValid_q) begin
                mainPay_d   = skidPay_q;
                skidValid_d = 1'b0;
            end else if (acceptIn) begin
                mainPay_d   = inPay;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (acceptIn) begin
            skidPay_d   = inPay;
            skidValid_d = 1'b1;
        end
    end

    // The stall counter sticks at all-ones so that a long hang remains
    // visible. A flush does not clear it; only reset does.
    always_comb begin
        stallCount_d = stallCount_q;
        if (mainValid_q && !MEM_ready && (stallCount_q != {NB_CNT{1'b1}})) begin
            stallCount_d = stallCount_q + 1'b1;
        end
    end

    // State registers. Payloads are also reset, so MEM_* never shows X.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mainValid_q  <= 1'b0;
            skidValid_q  <= 1'b0;
            mainPay_q    <= '0;
            skidPay_q    <= '0;
            stallCount_q <= '0;
        end else begin
            mainValid_q  <= mainValid_d;
            skidValid_q  <= skidValid_d;
            mainPay_q    <= mainPay_d;
            skidPay_q    <= skidPay_d;
            stallCount_q <= stallCount_d;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage.
// The reference model treats the stage as a two-deep FIFO (a queue) with a
// registered ready and a saturating stall counter. The stall counter is only
// 4 bits wide here, so saturation can be reached quickly.
module tb_ex_mem_stage;

    localparam int NB_PC   = 32;
    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_CTRL = 9;
    localparam int NB_CNT  = 4;
    localparam int NB_PAY  = 143;
    localparam int NB_OBS  = NB_PAY + 2 + NB_CNT;
    localparam logic [8:0] GATE_BITS = 9'h01D;

    typedef logic [NB_PAY-1:0] payT;
    typedef logic [NB_OBS-1:0] obsT;

    logic               clock;
    logic               resetN;
    logic               flush;
    logic               exValid;
    logic               exReady;
    payT                inPay;
    logic [NB_CTRL-1:0] exCtrl;
    logic [NB_PC-1:0]   exBranchAddr;
    logic               exZero;
    logic [NB_DATA-1:0] exAluResult;
    logic [NB_DATA-1:0] exDataA;
    logic [NB_REG-1:0]  exSelectedReg;
    logic [NB_PC-1:0]   exPc;
    logic               memValid;
    logic               memReady;
    logic [NB_CTRL-1:0] memCtrl;
    logic [NB_PC-1:0]   memBranchAddr;
    logic               memZero;
    logic [NB_DATA-1:0] memAluResult;
    logic [NB_DATA-1:0] memDataA;
    logic [NB_REG-1:0]  memSelectedReg;
    logic [NB_PC-1:0]   memPc;
    logic [NB_CNT-1:0]  stallCount;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state.
    payT modelQ[$];
    payT lastHead;
    int  modelCnt;

    assign {exCtrl, exBranchAddr, exZero, exAluResult, exDataA, exSelectedReg, exPc} = inPay;

    ex_mem_stage #(
        .NB_PC(NB_PC), .NB_DATA(NB_DATA), .NB_REG(NB_REG),
        .NB_CTRL(NB_CTRL), .NB_CNT(NB_CNT), .SIDE_EFFECT_MASK(9'b0_0001_1101)
    ) dut (
        .i_clock(clock), .i_reset_n(resetN), .i_flush(flush),
        .EX_valid(exValid), .EX_ready(exReady), .EX_ctrl(exCtrl),
        .EX_branch_addr(exBranchAddr), .EX_zero(exZero),
        .EX_alu_result(exAluResult), .EX_data_a(exDataA),
        .EX_selected_reg(exSelectedReg), .EX_pc(exPc),
        .MEM_valid(memValid), .MEM_ready(memReady), .MEM_ctrl(memCtrl),
        .MEM_branch_addr(memBranchAddr), .MEM_zero(memZero),
        .MEM_alu_result(memAluResult), .MEM_data_a(memDataA),
        .MEM_selected_reg(memSelectedReg), .MEM_pc(memPc),
        .o_stall_count(stallCount)
    );

    // Free-running clock with a 10-unit period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic payT randPay();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[NB_PAY-1:0];
    endfunction

    function automatic payT mkPay(input logic [8:0] ctrl, input logic [31:0] pc);
        payT p;
        p = randPay();
        p[142:134] = ctrl;
        p[31:0]    = pc;
        return p;
    endfunction

    function automatic obsT obsVec();
        return {memValid, exReady, memCtrl, memBranchAddr, memZero, memAluResult,
                memDataA, memSelectedReg, memPc, stallCount};
    endfunction

    // Expected outputs, derived from the FIFO view of the model.
    function automatic obsT expVec();
        payT h;
        logic v;
        v = (modelQ.size() > 0);
        h = v ? modelQ[0] : lastHead;
        if (!v) h[142:134] = h[142:134] & ~GATE_BITS;
        return {v, (modelQ.size() < 2), h, modelCnt[NB_CNT-1:0]};
    endfunction

    function automatic void modelReset();
        modelQ.delete();
        lastHead = '0;
        modelCnt = 0;
    endfunction

    // Advances one clock edge and applies the FIFO rules to the model, using
    // the state from before the edge. Outputs are sampled 1 unit later.
    task automatic cycle();
        int  preSize;
        logic canTake;
        @(posedge clock);
        preSize = modelQ.size();
        canTake = (preSize < 2);
        if (resetN) begin
            if (preSize > 0 && !memReady && modelCnt < 15) modelCnt++;
            if (flush) begin
                modelQ.delete();
            end else begin
                if (preSize > 0 && memReady) void'(modelQ.pop_front());
                if (exValid && canTake) modelQ.push_back(inPay);
            end
            if (modelQ.size() > 0) lastHead = modelQ[0];
        end
        #1;
    endtask

    task automatic applyStimulus(input logic v, input payT p, input logic rdy, input logic fl);
        exValid  = v;
        inPay    = p;
        memReady = rdy;
        flush    = fl;
    endtask

    task automatic doReset();
        resetN = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        modelReset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetN = 1'b1;
        #1;
    endtask

    // Reset state: nothing valid, ready high, gated ctrl and counter at zero.
    task automatic test_reset();
        doReset();
        vecCount++;
        if (obsVec() !== expVec()) begin
            missCount++;
            $display("[TB] FAIL reset_state: got %h required %h", obsVec(), expVec());
        end
        vecCount++;
        if ({memValid, exReady, memCtrl, stallCount} !== {1'b1 ^ 1'b1, 1'b1, 9'h000, 4'h0}) begin
            missCount++;
            $display("[TB] FAIL reset_flags: got v=%b r=%b c=%h n=%0d required v=0 r=1 c=000 n=0",
                     memValid, exReady, memCtrl, stallCount);
        end
    endtask

    // Four back-to-back instructions with MEM always ready.
    task automatic test_stream();
        logic [31:0] pcs[4] = '{32'h00, 32'h04, 32'h08, 32'h0C};
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, mkPay(9'($urandom()), pcs[i]), 1'b1, 1'b0);
            cycle();
            vecCount++;
            if (memPc !== pcs[i] || !memValid || !exReady || stallCount !== 4'd0) begin
                missCount++;
                $display("[TB] FAIL stream_pc%0d: got pc=%h v=%b r=%b n=%0d required pc=%h v=1 r=1 n=0",
                         i, memPc, memValid, exReady, stallCount, pcs[i]);
            end
            vecCount++;
            if (obsVec() !== expVec()) begin
                missCount++;
                $display("[TB] FAIL stream_vec%0d: got %h required %h", i, obsVec(), expVec());
            end
        end
    endtask

    // Skid fill under stall, then drain in order.
    task automatic test_skid();
        logic [31:0] expPc[4]   = '{32'h10, 32'h10, 32'h10, 32'h14};
        logic        expRdy[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0]  expCnt[4]  = '{4'd0, 4'd1, 4'd2, 4'd2};
        doReset();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: applyStimulus(1'b1, mkPay(9'h001, 32'h10), 1'b0, 1'b0);
                1: applyStimulus(1'b1, mkPay(9'h001, 32'h14), 1'b0, 1'b0);
                2: applyStimulus(1'b0, randPay(), 1'b0, 1'b0);
                default: applyStimulus(1'b0, randPay(), 1'b1, 1'b0);
            endcase
            cycle();
            if (i < 4) begin
                vecCount++;
                if (memPc !== expPc[i] || exReady !== expRdy[i] || stallCount !== expCnt[i] || !memValid) begin
                    missCount++;
                    $display("[TB] FAIL skid_step%0d: got pc=%h r=%b n=%0d v=%b required pc=%h r=%b n=%0d v=1",
                             i, memPc, exReady, stallCount, memValid, expPc[i], expRdy[i], expCnt[i]);
                end
            end else begin
                vecCount++;
                if (memValid !== 1'b0 || exReady !== 1'b1) begin
                    missCount++;
                    $display("[TB] FAIL skid_drained: got v=%b r=%b required v=0 r=1", memValid, exReady);
                end
            end
            vecCount++;
            if (obsVec() !== expVec()) begin
                missCount++;
                $display("[TB] FAIL skid_vec%0d: got %h required %h", i, obsVec(), expVec());
            end
        end
    endtask

    // Flush with both entries full and a same-cycle accept.
    task automatic test_flush();
        doReset();
        applyStimulus(1'b1, mkPay(9'h008, 32'h20), 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, mkPay(9'h008, 32'h24), 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, mkPay(9'h008, 32'h28), 1'b0, 1'b1);
        cycle();
        vecCount++;
        if (memValid !== 1'b0 || memCtrl[3] !== 1'b0 || exReady !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL flush_now: got v=%b ctrl3=%b r=%b required v=0 ctrl3=0 r=1",
                     memValid, memCtrl[3], exReady);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, randPay(), 1'b1, 1'b0);
            cycle();
            vecCount++;
            if (memValid !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL flush_ghost%0d: got v=%b pc=%h required v=0", i, memValid, memPc);
            end
            vecCount++;
            if (obsVec() !== expVec()) begin
                missCount++;
                $display("[TB] FAIL flush_vec%0d: got %h required %h", i, obsVec(), expVec());
            end
        end
    endtask

    // All-ones control held with no valid instruction: side effects stay off.
    task automatic test_bubble_gating();
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, mkPay(9'h1FF, 32'h40), 1'b1, 1'b0);
            cycle();
            vecCount++;
            if ((memCtrl & GATE_BITS) !== 9'h000 || memValid !== 1'b0) begin
                missCount++;
                $display("[TB] FAIL bubble_gate%0d: got ctrl=%h v=%b required ctrl&01d=000 v=0",
                         i, memCtrl, memValid);
            end
        end
        // A stale all-ones payload must be gated once the head drains.
        applyStimulus(1'b1, mkPay(9'h1FF, 32'h44), 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b0, randPay(), 1'b1, 1'b0);
        cycle();
        vecCount++;
        if (memCtrl !== 9'h1E2 || memPc !== 32'h44) begin
            missCount++;
            $display("[TB] FAIL bubble_stale: got ctrl=%h pc=%h required ctrl=1e2 pc=00000044", memCtrl, memPc);
        end
    endtask

    // Stall counter saturates at 15 with a 4-bit counter.
    task automatic test_saturation();
        doReset();
        applyStimulus(1'b1, mkPay(9'h005, 32'h50), 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, randPay(), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle();
            vecCount++;
            if (obsVec() !== expVec()) begin
                missCount++;
                $display("[TB] FAIL sat_vec%0d: got %h required %h", i, obsVec(), expVec());
            end
        end
        vecCount++;
        if (stallCount !== 4'd15) begin
            missCount++;
            $display("[TB] FAIL sat_final: got %0d required 15", stallCount);
        end
        applyStimulus(1'b0, randPay(), 1'b1, 1'b1);
        cycle();
        vecCount++;
        if (stallCount !== 4'd15 || memValid !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL sat_after_flush: got n=%0d v=%b required n=15 v=0", stallCount, memValid);
        end
    endtask

    // Asynchronous reset in the middle of a stall with both entries full.
    task automatic test_async_reset();
        doReset();
        applyStimulus(1'b1, mkPay(9'h00D, 32'h60), 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, mkPay(9'h00D, 32'h64), 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, randPay(), 1'b0, 1'b0);
        cycle();
        cycle();
        #2;
        resetN = 1'b0;
        modelReset();
        #1;
        vecCount++;
        if (memValid !== 1'b0 || exReady !== 1'b1 || stallCount !== 4'd0 || memCtrl !== 9'h000) begin
            missCount++;
            $display("[TB] FAIL async_reset: got v=%b r=%b n=%0d c=%h required v=0 r=1 n=0 c=000",
                     memValid, exReady, stallCount, memCtrl);
        end
        @(negedge clock);
        resetN = 1'b1;
    endtask

    // Random traffic checked cycle by cycle against the FIFO model.
    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randPay(),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            cycle();
            vecCount++;
            if (obsVec() !== expVec()) begin
                missCount++;
                $display("[TB] FAIL random_vec%0d: got %h required %h", i, obsVec(), expVec());
            end
        end
    endtask

    // Runs every scenario in order, then prints the summary.
    initial begin
        resetN = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        modelReset();
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_bubble_gating();
        test_saturation();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
